// File: rtl/image_transform_engine.sv
`timescale 1ns/1ps
// In-place image mirror (horizontal/vertical) with optional pixel inversion over a 2R/2W memory.
// Latency: 2 cycles per visited pixel pair (read, then swap-write), plus one DONE cycle.
// No backpressure: memory is assumed to accept every read/write in the cycle it is issued.
module image_transform_engine #(
    parameter int               IMG_W    = 320,
    parameter int               IMG_H    = 240,
    parameter int               PIX_W    = 32,
    parameter int               ADDR_W   = 17,
    parameter logic [PIX_W-1:0] INV_MASK = PIX_W'(32'h00FF_FFFF)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              flip_h,
    input  logic              flip_v,
    input  logic              invert,
    output logic              busy,
    output logic              done,
    output logic              rd0_en,
    output logic [ADDR_W-1:0] rd0_addr,
    input  logic [PIX_W-1:0]  rd0_data,
    output logic              rd1_en,
    output logic [ADDR_W-1:0] rd1_addr,
    input  logic [PIX_W-1:0]  rd1_data,
    output logic              wr0_en,
    output logic [ADDR_W-1:0] wr0_addr,
    output logic [PIX_W-1:0]  wr0_data,
    output logic              wr1_en,
    output logic [ADDR_W-1:0] wr1_addr,
    output logic [PIX_W-1:0]  wr1_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LP_W          = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] LP_W_M1       = ADDR_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] LP_H_M1       = ADDR_W'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] LP_HALF_W_M1  = ADDR_W'((IMG_W + 1) / 2 - 1);
    localparam logic [ADDR_W-1:0] LP_HALF_H_M1  = ADDR_W'((IMG_H + 1) / 2 - 1);
    localparam logic [ADDR_W-1:0] LP_MID_ROW    = ADDR_W'(IMG_H / 2);
    localparam bit                LP_H_ODD      = (IMG_H % 2) == 1;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_row;
    logic [ADDR_W-1:0]   r_col;
    logic                r_fh;
    logic                r_fv;
    logic                r_inv;

    logic [ADDR_W-1:0]   w_row_p;
    logic [ADDR_W-1:0]   w_col_p;
    logic [ADDR_W-1:0]   w_own_addr;
    logic [ADDR_W-1:0]   w_part_addr;
    logic                w_self;
    logic                w_half_cols;
    logic [ADDR_W-1:0]   w_col_last;
    logic [ADDR_W-1:0]   w_row_last;
    logic                w_last_elem;
    logic [PIX_W-1:0]    w_src0;

    // Partner coordinates/addresses and the shape of the visit set for the current row.
    // With both flips and an odd height, the middle row mirrors onto itself, so only
    // its left half (plus the centre column) is visited; every other row is visited in full.
    always_comb begin
        w_row_p     = r_fv ? (LP_H_M1 - r_row) : r_row;
        w_col_p     = r_fh ? (LP_W_M1 - r_col) : r_col;
        w_own_addr  = r_row * LP_W + r_col;
        w_part_addr = w_row_p * LP_W + w_col_p;
        w_self      = (w_own_addr == w_part_addr);
        w_half_cols = r_fh && (!r_fv || (LP_H_ODD && (r_row == LP_MID_ROW)));
        w_col_last  = w_half_cols ? LP_HALF_W_M1 : LP_W_M1;
        w_row_last  = r_fv ? LP_HALF_H_M1 : LP_H_M1;
        w_last_elem = (r_col == w_col_last) && (r_row == w_row_last);
        // A self-paired pixel only has port-0 read data; port 1 was never enabled.
        w_src0      = w_self ? rd0_data : rd1_data;
    end

    // Sequencer: latch modes on start, then alternate read/swap-write per visit element.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_row   <= '0;
            r_col   <= '0;
            r_fh    <= 1'b0;
            r_fv    <= 1'b0;
            r_inv   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_fh    <= flip_h;
                        r_fv    <= flip_v;
                        r_inv   <= invert;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_state <= S_RD;
                    end
                end
                S_RD: begin
                    r_state <= S_WR;
                end
                S_WR: begin
                    if (r_col == w_col_last) begin
                        r_col <= '0;
                        r_row <= r_row + 1'b1;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                    r_state <= w_last_elem ? S_DONE : S_RD;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Memory port and status decode; everything keys off the registered state so
    // a reset drops all enables in the same cycle.
    always_comb begin
        busy     = (r_state == S_RD) || (r_state == S_WR);
        done     = (r_state == S_DONE);
        rd0_en   = (r_state == S_RD);
        rd1_en   = (r_state == S_RD) && !w_self;
        rd0_addr = w_own_addr;
        rd1_addr = w_part_addr;
        wr0_en   = (r_state == S_WR);
        wr1_en   = (r_state == S_WR) && !w_self;
        wr0_addr = w_own_addr;
        wr1_addr = w_part_addr;
        wr0_data = r_inv ? (w_src0 ^ INV_MASK) : w_src0;
        wr1_data = r_inv ? (rd0_data ^ INV_MASK) : rd0_data;
    end

endmodule

// File: tb/tb_image_transform_engine.sv
`timescale 1ns/1ps
module tb_image_transform_engine;

    localparam int NI = 5;
    localparam int AW = 17;
    localparam int MW = 76800;

    function automatic int f_w(input int g);
        case (g)
            0: return 4;
            1: return 3;
            2: return 2;
            3: return 320;
            default: return 1;
        endcase
    endfunction

    function automatic int f_h(input int g);
        case (g)
            0: return 2;
            1: return 3;
            2: return 2;
            3: return 240;
            default: return 3;
        endcase
    endfunction

    function automatic logic [31:0] pat(input int kind, input int a);
        logic [31:0] x;
        x = 32'(a);
        case (kind)
            0: return x;
            1: return 32'hFF00_0000;
            default: return (x * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
        endcase
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    logic flip_h, flip_v, invert;
    logic start_v   [NI];
    logic busy_v    [NI];
    logic done_v    [NI];
    logic rd0_en_v  [NI];
    logic rd1_en_v  [NI];
    logic wr0_en_v  [NI];
    logic wr1_en_v  [NI];
    logic [AW-1:0] rd0_addr_v [NI];
    logic [AW-1:0] rd1_addr_v [NI];
    logic [AW-1:0] wr0_addr_v [NI];
    logic [AW-1:0] wr1_addr_v [NI];
    logic [31:0]   rd0_data_v [NI];
    logic [31:0]   rd1_data_v [NI];
    logic [31:0]   wr0_data_v [NI];
    logic [31:0]   wr1_data_v [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        image_transform_engine #(
            .IMG_W(f_w(g)), .IMG_H(f_h(g)), .PIX_W(32), .ADDR_W(AW), .INV_MASK(32'h00FF_FFFF)
        ) u_dut (
            .clk(clk), .reset_n(reset_n), .start(start_v[g]),
            .flip_h(flip_h), .flip_v(flip_v), .invert(invert),
            .busy(busy_v[g]), .done(done_v[g]),
            .rd0_en(rd0_en_v[g]), .rd0_addr(rd0_addr_v[g]), .rd0_data(rd0_data_v[g]),
            .rd1_en(rd1_en_v[g]), .rd1_addr(rd1_addr_v[g]), .rd1_data(rd1_data_v[g]),
            .wr0_en(wr0_en_v[g]), .wr0_addr(wr0_addr_v[g]), .wr0_data(wr0_data_v[g]),
            .wr1_en(wr1_en_v[g]), .wr1_addr(wr1_addr_v[g]), .wr1_data(wr1_data_v[g])
        );
    end

    // Memory models, bulk loader and protocol monitors for all instances.
    logic [31:0] mem [NI][MW];
    int n_done [NI] = '{default: 0};
    int n_wr0  [NI] = '{default: 0};
    int n_wr1  [NI] = '{default: 0};
    int n_evt  [NI] = '{default: 0};
    logic ld_en = 1'b0;
    int   ld_g  = 0;
    int   ld_kind = 0;

    always @(posedge clk) begin
        if (ld_en) begin
            for (int a = 0; a < MW; a++) mem[ld_g][a] <= pat(ld_kind, a);
        end
        for (int g = 0; g < NI; g++) begin
            if (rd0_en_v[g]) rd0_data_v[g] <= mem[g][rd0_addr_v[g]];
            if (rd1_en_v[g]) rd1_data_v[g] <= mem[g][rd1_addr_v[g]];
            if (wr0_en_v[g]) begin
                mem[g][wr0_addr_v[g]] <= wr0_data_v[g];
                n_wr0[g] <= n_wr0[g] + 1;
            end
            if (wr1_en_v[g]) begin
                mem[g][wr1_addr_v[g]] <= wr1_data_v[g];
                n_wr1[g] <= n_wr1[g] + 1;
            end
            if (done_v[g]) n_done[g] <= n_done[g] + 1;
            if ((wr0_en_v[g] && wr1_en_v[g] && (wr0_addr_v[g] == wr1_addr_v[g])) ||
                ((rd0_en_v[g] || rd1_en_v[g] || wr0_en_v[g] || wr1_en_v[g]) && !busy_v[g]))
                n_evt[g] <= n_evt[g] + 1;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic load(input int g, input int kind);
        @(negedge clk);
        ld_g    = g;
        ld_kind = kind;
        ld_en   = 1'b1;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    // One transform on instance g; modes are flipped right after the start edge and,
    // with poke set, start is re-pulsed while busy and again during the done cycle.
    task automatic run(input int g, input bit fh, input bit fv, input bit inv,
                       input int exp_cyc, input bit poke, input string tag);
        int n;
        int d0;
        d0 = n_done[g];
        @(negedge clk);
        flip_h = fh; flip_v = fv; invert = inv;
        start_v[g] = 1'b1;
        @(posedge clk);
        #1;
        start_v[g] = 1'b0;
        flip_h = ~flip_h; flip_v = ~flip_v; invert = ~invert;
        chk({tag, "_busy"}, 64'(busy_v[g]), 64'd1);
        n = 1;
        while (!done_v[g] && n < exp_cyc + 20) begin
            @(posedge clk);
            #1;
            n++;
            if (poke && n == 3) start_v[g] = 1'b1;
            if (poke && n == 4) start_v[g] = 1'b0;
        end
        chk({tag, "_cyc"}, 64'(n), 64'(exp_cyc));
        chk({tag, "_busy_at_done"}, 64'(busy_v[g]), 64'd0);
        if (poke) start_v[g] = 1'b1;
        @(posedge clk);
        #1;
        start_v[g] = 1'b0;
        chk({tag, "_done_1cyc"}, 64'(done_v[g]), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_idle"}, 64'(busy_v[g]), 64'd0);
        chk({tag, "_ndone"}, 64'(n_done[g] - d0), 64'd1);
    endtask

    logic [31:0] e8 [8];
    logic [31:0] e9 [9];
    logic [31:0] e3 [3];

    initial begin
        int w0, w1, errs, a, evt;
        reset_n = 1'b0;
        flip_h = 1'b0; flip_v = 1'b0; invert = 1'b0;
        for (int g = 0; g < NI; g++) start_v[g] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < NI; g++) begin
            chk("rst_busy", 64'(busy_v[g]), 64'd0);
            chk("rst_done", 64'(done_v[g]), 64'd0);
            chk("rst_en", 64'({rd0_en_v[g], rd1_en_v[g], wr0_en_v[g], wr1_en_v[g]}), 64'd0);
        end
        @(negedge clk);
        reset_n = 1'b1;

        // 4x2 horizontal mirror
        load(0, 0);
        run(0, 1'b1, 1'b0, 1'b0, 9, 1'b0, "fh4x2");
        e8 = '{3, 2, 1, 0, 7, 6, 5, 4};
        for (int i = 0; i < 8; i++) chk("fh4x2_pix", 64'(mem[0][i]), 64'(e8[i]));

        // 3x3 both flips, start re-pulsed while busy
        load(1, 0);
        w0 = n_wr0[1]; w1 = n_wr1[1];
        run(1, 1'b1, 1'b1, 1'b0, 11, 1'b1, "hv3x3");
        e9 = '{8, 7, 6, 5, 4, 3, 2, 1, 0};
        for (int i = 0; i < 9; i++) chk("hv3x3_pix", 64'(mem[1][i]), 64'(e9[i]));
        chk("hv3x3_wr0", 64'(n_wr0[1] - w0), 64'd5);
        chk("hv3x3_wr1", 64'(n_wr1[1] - w1), 64'd4);

        // 2x2 invert only: every pixel is its own partner
        load(2, 1);
        w0 = n_wr0[2]; w1 = n_wr1[2];
        run(2, 1'b0, 1'b0, 1'b1, 9, 1'b0, "inv2x2");
        for (int i = 0; i < 4; i++) chk("inv2x2_pix", 64'(mem[2][i]), 64'h0000_0000_FFFF_FFFF);
        chk("inv2x2_wr0", 64'(n_wr0[2] - w0), 64'd4);
        chk("inv2x2_wr1", 64'(n_wr1[2] - w1), 64'd0);

        // 1x3 column, both flips: one pair plus a self-paired middle
        load(4, 0);
        w1 = n_wr1[4];
        run(4, 1'b1, 1'b1, 1'b0, 5, 1'b0, "hv1x3");
        e3 = '{2, 1, 0};
        for (int i = 0; i < 3; i++) chk("hv1x3_pix", 64'(mem[4][i]), 64'(e3[i]));
        chk("hv1x3_wr1", 64'(n_wr1[4] - w1), 64'd1);

        // 320x240 horizontal mirror with inversion against a reference image
        load(3, 2);
        run(3, 1'b1, 1'b0, 1'b1, 2 * 38400 + 1, 1'b0, "big");
        errs = 0;
        for (int r = 0; r < 240; r++) begin
            for (int c = 0; c < 320; c++) begin
                a = r * 320 + c;
                if (mem[3][a] !== (pat(2, r * 320 + 319 - c) ^ 32'h00FF_FFFF)) errs++;
            end
        end
        chk("big_pix_errs", 64'(errs), 64'd0);

        // Reset during cycle 5 of a 4x2 horizontal mirror
        load(0, 0);
        @(negedge clk);
        flip_h = 1'b1; flip_v = 1'b0; invert = 1'b0;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("abort_en", 64'({rd0_en_v[0], rd1_en_v[0], wr0_en_v[0], wr1_en_v[0]}), 64'd0);
        chk("abort_busy", 64'(busy_v[0]), 64'd0);
        w0 = n_wr0[0] + n_wr1[0];
        w1 = n_done[0];
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("abort_writes", 64'(n_wr0[0] + n_wr1[0] - w0), 64'd0);
        chk("abort_done", 64'(n_done[0] - w1), 64'd0);
        e8 = '{3, 2, 1, 0, 4, 5, 6, 7};
        for (int i = 0; i < 8; i++) chk("abort_pix", 64'(mem[0][i]), 64'(e8[i]));
        run(0, 1'b1, 1'b0, 1'b0, 9, 1'b0, "rerun");
        e8 = '{0, 1, 2, 3, 7, 6, 5, 4};
        for (int i = 0; i < 8; i++) chk("rerun_pix", 64'(mem[0][i]), 64'(e8[i]));

        evt = 0;
        for (int g = 0; g < NI; g++) evt += n_evt[g];
        chk("protocol_evts", 64'(evt), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/image_transform_engine.md
IMAGE_TRANSFORM_ENGINE -- requirements
Module: image_transform_engine

Interface
REQ-001 SHALL have parameter IMG_W, default 320, image width in pixels (>=1).
REQ-002 SHALL have parameter IMG_H, default 240, image height in pixels (>=1).
REQ-003 SHALL have parameter PIX_W, default 32, memory word / pixel width in bits.
REQ-004 SHALL have parameter ADDR_W, default 17, memory address width; IMG_W*IMG_H <= 2**ADDR_W.
REQ-005 SHALL have parameter INV_MASK, default 32'h00FF_FFFF, PIX_W-bit mask of bits inverted by invert mode.
REQ-006 SHALL have one clock and an asynchronous, active-low reset: clk and reset_n.
REQ-007 clk  input  1  rising-edge clock for all state.
REQ-008 reset_n  input  1  asynchronous active-low reset.
REQ-009 start  input  1  single-cycle request to begin a transform.
REQ-010 flip_h  input  1  mirror columns; sampled with start.
REQ-011 flip_v  input  1  mirror rows; sampled with start.
REQ-012 invert  input  1  XOR each pixel with INV_MASK; sampled with start.
REQ-013 busy  output  1  high from the cycle after accepted start until done.
REQ-014 done  output  1  one-cycle pulse at transform completion.
REQ-015 rd0_en/rd1_en  output  1 each  read-port enables.
REQ-016 rd0_addr/rd1_addr  output  ADDR_W each  read addresses.
REQ-017 rd0_data/rd1_data  input  PIX_W each  read data, valid exactly 1 cycle after the enable.
REQ-018 wr0_en/wr1_en  output  1 each  write-port enables.
REQ-019 wr0_addr/wr1_addr  output  ADDR_W each  write addresses.
REQ-020 wr0_data/wr1_data  output  PIX_W each  write data.

Function
REQ-021 Pixel (r,c) SHALL be at linear address r*IMG_W+c; the transform SHALL be in place.
REQ-022 Partner of (r,c): row rp = flip_v ? IMG_H-1-r : r, col cp = flip_h ? IMG_W-1-c : c.
REQ-023 Visit set SHALL contain each pair exactly once: flip_h only -> all rows, cols 0..ceil(W/2)-1; flip_v only -> rows 0..ceil(H/2)-1, all cols; both -> rows 0..ceil(H/2)-1, all cols, except when H is odd the middle row uses cols 0..ceil(W/2)-1; neither -> all pixels.
REQ-024 Visit order SHALL be row-major ascending (r outer, c inner).
REQ-025 FSM states SHALL be IDLE, RD, WR, DONE.
REQ-026 IDLE: start=1 latches flip_h/flip_v/invert, clears row/col counters, goes to RD; otherwise stays.
REQ-027 RD: rd0_en=1 at own address, rd1_en=1 at partner address; next state WR.
REQ-028 WR: wr0 writes f(rd1_data) to own address, wr1 writes f(rd0_data) to partner address, with f(x)=invert ? x^INV_MASK : x; counters advance; next state RD, or DONE after the last visit element.
REQ-029 Self-paired pixel (partner address == own address): only port 0 reads and writes; rd1_en=0 and wr1_en=0.
REQ-030 DONE: done=1 for exactly one cycle; busy=0; next state IDLE.
REQ-031 Latency: with P visit elements, done SHALL assert 2*P+1 cycles after the start-sampling edge.
REQ-032 start during RD/WR/DONE SHALL be ignored; mode inputs changing mid-run SHALL have no effect.
REQ-033 All enables SHALL be 0 in IDLE and DONE; the two write ports SHALL never target the same address in one cycle.
REQ-034 IMG_W=1 or IMG_H=1 SHALL work (degenerate pairs become self-pairs).

Reset
REQ-035 On reset_n=0, state=IDLE, counters=0, latched modes=0, busy=0, done=0, all enables=0, immediately and asynchronously.
REQ-036 Reset mid-run SHALL abort with no further reads or writes; pixels already written remain as written.
REQ-037 First start after reset release SHALL be accepted normally.

Verification
REQ-038 4x2 image, pixels = address, flip_h only: rows become {3,2,1,0},{7,6,5,4}; P=4; done 9 cycles after start.
REQ-039 3x3 image, flip_h+flip_v, no invert: result = reverse of 0..8; centre pixel 4 single-port accessed; P=5; done at 11 cycles.
REQ-040 2x2 image, invert only, pixel 32'hFF00_0000: result 32'hFFFF_FFFF; P=4; wr1_en never asserted.
REQ-041 320x240 defaults, flip_h+invert from a known image: output equals software model; done at 2*38400+1 cycles.
REQ-042 Assert reset_n low at cycle 5 of a run: all enables drop the same cycle, done never pulses; a subsequent start completes correctly.
REQ-043 start pulsed while busy: ignored, single done pulse, memory contents identical to a single run.
